// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver.
// Collects WIDTH serial bits framed by sin_start into a parallel word and
// presents it on a valid/ready output. Words that complete while the
// previous word is still unconsumed are dropped, and overrun is raised.
// A new sin_start in the middle of a word abandons that word, raises
// frame_err for one cycle, and starts a new word.
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | no word in progress; waiting for sin_start
// SHIFT  | partial word held in shreg, cnt bits captured so far
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_start,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             done;
    logic             restart;
    logic             load;
    logic             drop;

    // Shift register image after capturing the current sin, and the image
    // of a freshly started word holding only its first bit.
    always_comb begin
        shifted    = '0;
        first_word = '0;
        if (MSB_FIRST) begin
            shifted       = {shreg[WIDTH-2:0], sin};
            first_word[0] = sin;
        end else begin
            shifted             = {sin, shreg[WIDTH-1:1]};
            first_word[WIDTH-1] = sin;
        end
    end

    // Next-state, bit counter and shift register update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        done      = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                if (sin_start) begin
                    shreg_nxt = first_word;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sin_start) begin
                    restart   = 1'b1;
                    shreg_nxt = first_word;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    done      = 1'b1;
                    shreg_nxt = shifted;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    shreg_nxt = shifted;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A completed word is accepted when the output slot is empty or is
    // being emptied on this same edge; otherwise it is lost.
    assign load = done && (!pout_valid || out_ready);
    assign drop = done && pout_valid && !out_ready;
    assign busy = (state == S_SHIFT);

    // Receiver state registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Output word register with valid/ready handshake.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pout       <= '0;
            pout_valid <= 1'b0;
        end else if (load) begin
            pout       <= shifted;
            pout_valid <= 1'b1;
        end else if (pout_valid && out_ready) begin
            pout_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // One-cycle frame error pulse following an abandoned partial word.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= restart;
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed bench for sipo_rx with an expected-word scoreboard.
// Two instances share all stimulus: one MSB-first, one LSB-first.
module tb_sipo_rx;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       sin;
    logic       sin_start;
    logic       out_ready;
    logic       overrun_clr;

    logic [3:0] pout_m, pout_l;
    logic       valid_m, valid_l;
    logic       busy_m, busy_l;
    logic       ovr_m, ovr_l;
    logic       ferr_m, ferr_l;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_lq[$];

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .rst_n(rst_n), .sin(sin), .sin_start(sin_start),
        .out_ready(out_ready), .overrun_clr(overrun_clr),
        .pout(pout_m), .pout_valid(valid_m), .busy(busy_m),
        .overrun(ovr_m), .frame_err(ferr_m)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .rst_n(rst_n), .sin(sin), .sin_start(sin_start),
        .out_ready(out_ready), .overrun_clr(overrun_clr),
        .pout(pout_l), .pout_valid(valid_l), .busy(busy_l),
        .overrun(ovr_l), .frame_err(ferr_l)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected word and compare both instances' pout.
    task automatic chk_pop(input string tag);
        logic [3:0] e, el;
        if (exp_q.size() == 0 || exp_lq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=scoreboard_empty expected=word", tag);
        end else begin
            e  = exp_q.pop_front();
            el = exp_lq.pop_front();
            chk({tag, "_valid"}, {31'd0, valid_m}, 32'd1);
            chk({tag, "_msb"}, {28'd0, pout_m}, {28'd0, e});
            chk({tag, "_lsb"}, {28'd0, pout_l}, {28'd0, el});
        end
    endtask

    // Send one 4-bit word in serial order (w[3] first). rdy[3] applies to the
    // first bit. The expected word is queued when the word should be kept.
    task automatic send_word(input logic [3:0] w, input logic [3:0] rdy, input bit push);
        if (push) begin
            exp_q.push_back(w);
            exp_lq.push_back(rev4(w));
        end
        for (int i = 0; i < 4; i++) begin
            sin       = w[3-i];
            sin_start = (i == 0);
            out_ready = rdy[3-i];
            tick();
        end
        sin_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pout_m"},  {28'd0, pout_m}, 32'd0);
        chk({tag, "_pout_l"},  {28'd0, pout_l}, 32'd0);
        chk({tag, "_valid"},   {30'd0, valid_m, valid_l}, 32'd0);
        chk({tag, "_busy"},    {30'd0, busy_m, busy_l}, 32'd0);
        chk({tag, "_overrun"}, {30'd0, ovr_m, ovr_l}, 32'd0);
        chk({tag, "_ferr"},    {30'd0, ferr_m, ferr_l}, 32'd0);
    endtask

    initial begin
        logic [3:0] bits;

        rst_n       = 1'b0;
        sin         = 1'b0;
        sin_start   = 1'b0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic word 1010: busy for three cycles, valid after the fourth edge.
        bits = 4'b1010;
        exp_q.push_back(bits);
        exp_lq.push_back(rev4(bits));
        for (int i = 0; i < 4; i++) begin
            sin       = bits[3-i];
            sin_start = (i == 0);
            tick();
            if (i < 3) begin
                chk("basic_busy", {31'd0, busy_m}, 32'd1);
                chk("basic_novalid", {31'd0, valid_m}, 32'd0);
            end
        end
        sin_start = 1'b0;
        chk("basic_idle", {31'd0, busy_m}, 32'd0);
        chk_pop("basic");
        tick();
        chk("basic_consumed", {31'd0, valid_m}, 32'd0);

        // Back-to-back words without an idle bubble.
        send_word(4'b1010, 4'b1111, 1'b1);
        chk_pop("b2b_first");
        send_word(4'b0101, 4'b1111, 1'b1);
        chk_pop("b2b_second");
        chk("b2b_overrun", {31'd0, ovr_m}, 32'd0);
        tick();

        // Stall: second word is dropped and overrun set.
        send_word(4'b1010, 4'b0000, 1'b1);
        send_word(4'b0110, 4'b0000, 1'b0);
        chk("stall_overrun", {31'd0, ovr_m}, 32'd1);
        chk_pop("stall_hold");
        out_ready = 1'b1;
        tick();
        chk("stall_drain", {31'd0, valid_m}, 32'd0);
        chk("stall_sticky", {31'd0, ovr_m}, 32'd1);
        overrun_clr = 1'b1;
        tick();
        chk("stall_clr", {31'd0, ovr_m}, 32'd0);
        overrun_clr = 1'b0;

        // Drop coinciding with overrun_clr: set wins.
        send_word(4'b0011, 4'b0000, 1'b1);
        overrun_clr = 1'b1;
        send_word(4'b1111, 4'b0000, 1'b0);
        chk("setwins_overrun", {31'd0, ovr_m}, 32'd1);
        chk_pop("setwins_hold");
        out_ready = 1'b1;
        tick();
        chk("setwins_drain", {31'd0, valid_m}, 32'd0);
        chk("setwins_clr", {31'd0, ovr_m}, 32'd0);
        overrun_clr = 1'b0;

        // Transfer and completion on the same edge.
        send_word(4'b1100, 4'b0000, 1'b1);
        chk_pop("simul_first");
        send_word(4'b0110, 4'b0001, 1'b1);
        chk_pop("simul_second");
        chk("simul_overrun", {31'd0, ovr_m}, 32'd0);
        tick();
        chk("simul_drain", {31'd0, valid_m}, 32'd0);

        // Restart mid-word: 1,1 then a new word 0011.
        sin = 1'b1; sin_start = 1'b1; tick();
        sin = 1'b1; sin_start = 1'b0; tick();
        chk("restart_noerr", {31'd0, ferr_m}, 32'd0);
        exp_q.push_back(4'b0011);
        exp_lq.push_back(rev4(4'b0011));
        bits = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            sin       = bits[3-i];
            sin_start = (i == 0);
            tick();
            if (i == 0) chk("restart_ferr_pulse", {30'd0, ferr_m, ferr_l}, 32'd3);
            if (i == 1) chk("restart_ferr_end", {31'd0, ferr_m}, 32'd0);
        end
        sin_start = 1'b0;
        chk_pop("restart_word");
        tick();

        // Reset mid-word with a held word and overrun pending.
        send_word(4'b1001, 4'b0000, 1'b1);
        chk_pop("prereset_word");
        send_word(4'b0111, 4'b0000, 1'b0);
        sin = 1'b1; sin_start = 1'b1; tick();
        sin = 1'b0; sin_start = 1'b0; tick();
        chk("prereset_busy", {31'd0, busy_m}, 32'd1);
        chk("prereset_overrun", {31'd0, ovr_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_word(4'b1100, 4'b1111, 1'b1);
        chk_pop("postreset_word");
        tick();

        // LSB-first placement: 1,0,0,0 -> 0001 on the LSB-first instance.
        send_word(4'b1000, 4'b1111, 1'b1);
        chk("lsb_first_0001", {28'd0, pout_l}, 32'd1);
        chk_pop("lsb_first");
        tick();
        chk("final_drain", {30'd0, valid_m, valid_l}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
